// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the RV32I control path: opcodes, FSM states,
// ALU command codes and datapath mux selects.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EX_R     = 4'd2;
    localparam logic [3:0] S_EX_I     = 4'd3;
    localparam logic [3:0] S_EX_U     = 4'd4;
    localparam logic [3:0] S_EX_JAL   = 4'd5;
    localparam logic [3:0] S_EX_JALR  = 4'd6;
    localparam logic [3:0] S_EX_BR    = 4'd7;
    localparam logic [3:0] S_MEM_ADDR = 4'd8;
    localparam logic [3:0] S_MEM_RD   = 4'd9;
    localparam logic [3:0] S_MEM_WR   = 4'd10;
    localparam logic [3:0] S_WB_ALU   = 4'd11;
    localparam logic [3:0] S_WB_MEM   = 4'd12;
    localparam logic [3:0] S_TRAP     = 4'd13;

    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [3:0] ALU_SUB     = 4'b0001;
    localparam logic [3:0] ALU_PASS_B  = 4'b0101;
    localparam logic [3:0] ALU_I_FUNCT = 4'b0110;
    localparam logic [3:0] ALU_R_FUNCT = 4'b0111;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;

    localparam logic [1:0] A_PC     = 2'b00;
    localparam logic [1:0] A_RS1    = 2'b01;
    localparam logic [1:0] A_OLD_PC = 2'b10;
    localparam logic [1:0] A_ZERO   = 2'b11;

    localparam logic [1:0] B_RS2  = 2'b00;
    localparam logic [1:0] B_IMM  = 2'b01;
    localparam logic [1:0] B_FOUR = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC4    = 2'b10;

    function automatic logic [3:0] decode_next(input logic [6:0] op);
        case (op)
            OP_R:              decode_next = S_EX_R;
            OP_I:              decode_next = S_EX_I;
            OP_LUI, OP_AUIPC:  decode_next = S_EX_U;
            OP_JAL:            decode_next = S_EX_JAL;
            OP_JALR:           decode_next = S_EX_JALR;
            OP_BR:             decode_next = S_EX_BR;
            OP_LOAD, OP_STORE: decode_next = S_MEM_ADDR;
            default:           decode_next = S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_branch.sv
// Branch condition from SUB flags; flags unsupported funct3 codes.
module branch_resolve (
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            3'b000:  taken = alu_zero;
            3'b001:  taken = ~alu_zero;
            3'b100:  taken = alu_lt;
            3'b101:  taken = ~alu_lt;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: FSM driving a shared ALU and unified
// memory, with a memory-wait watchdog that traps on timeout.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] aluop,
    output logic       reg_write,
    output logic [1:0] wb_src,
    output logic       trap
);

    logic [3:0]       state;
    logic [3:0]       state_nx;
    logic             live;
    logic [CNT_W-1:0] wdog;
    logic             waiting;
    logic             timeout;
    logic             br_taken;
    logic             br_bad;

    branch_resolve u_br (
        .funct3   (funct3),
        .alu_zero (alu_zero),
        .alu_lt   (alu_lt),
        .taken    (br_taken),
        .illegal  (br_bad)
    );

    assign waiting = live && !mem_ready &&
                     (state == S_FETCH || state == S_MEM_RD || state == S_MEM_WR);
    assign timeout = waiting && (wdog == CNT_W'(MEM_TIMEOUT - 1));

    // live holds outputs quiet for the cycle after reset so a pending request drops
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            live  <= 1'b0;
            wdog  <= '0;
        end else begin
            live  <= 1'b1;
            state <= state_nx;
            if (state_nx != state)
                wdog <= '0;
            else if (waiting)
                wdog <= wdog + 1'b1;
        end
    end

    always_comb begin
        state_nx  = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_ALU;
        alu_src_a = A_PC;
        alu_src_b = B_RS2;
        aluop     = ALU_ADD;
        reg_write = 1'b0;
        wb_src    = WB_ALUOUT;
        trap      = 1'b0;
        if (live) begin
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_a = A_PC;
                    alu_src_b = B_FOUR;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_nx = S_DECODE;
                    end else if (timeout) begin
                        state_nx = S_TRAP;
                    end
                end
                S_DECODE: begin
                    alu_src_a = A_OLD_PC;
                    alu_src_b = B_IMM;
                    state_nx  = decode_next(op);
                end
                S_EX_R: begin
                    alu_src_a = A_RS1;
                    aluop     = ALU_R_FUNCT;
                    state_nx  = S_WB_ALU;
                end
                S_EX_I: begin
                    alu_src_a = A_RS1;
                    alu_src_b = B_IMM;
                    aluop     = ALU_I_FUNCT;
                    state_nx  = S_WB_ALU;
                end
                S_EX_U: begin
                    alu_src_a = (op == OP_LUI) ? A_ZERO : A_OLD_PC;
                    alu_src_b = B_IMM;
                    state_nx  = S_WB_ALU;
                end
                S_EX_JAL: begin
                    reg_write = 1'b1;
                    wb_src    = WB_PC4;
                    pc_write  = 1'b1;
                    pc_src    = PC_ALUOUT;
                    state_nx  = S_FETCH;
                end
                S_EX_JALR: begin
                    alu_src_a = A_RS1;
                    alu_src_b = B_IMM;
                    reg_write = 1'b1;
                    wb_src    = WB_PC4;
                    pc_write  = 1'b1;
                    pc_src    = PC_JALR;
                    state_nx  = S_FETCH;
                end
                S_EX_BR: begin
                    alu_src_a = A_RS1;
                    alu_src_b = B_RS2;
                    aluop     = ALU_SUB;
                    pc_src    = PC_ALUOUT;
                    pc_write  = br_taken && !br_bad;
                    state_nx  = br_bad ? S_TRAP : S_FETCH;
                end
                S_MEM_ADDR: begin
                    alu_src_a = A_RS1;
                    alu_src_b = B_IMM;
                    state_nx  = (op == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    if (mem_ready)
                        state_nx = S_WB_MEM;
                    else if (timeout)
                        state_nx = S_TRAP;
                end
                S_MEM_WR: begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    addr_sel = 1'b1;
                    if (mem_ready)
                        state_nx = S_FETCH;
                    else if (timeout)
                        state_nx = S_TRAP;
                end
                S_WB_ALU: begin
                    reg_write = 1'b1;
                    wb_src    = WB_ALUOUT;
                    state_nx  = S_FETCH;
                end
                S_WB_MEM: begin
                    reg_write = 1'b1;
                    wb_src    = WB_MDR;
                    state_nx  = S_FETCH;
                end
                S_TRAP: begin
                    trap = 1'b1;
                end
                default: begin
                    state_nx = S_TRAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Random instruction streams against a per-instruction cycle-script
// reference model of the multi-cycle controller.
module tb_multicycle_control;

    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b0001;
    localparam logic [3:0] IFN = 4'b0110;
    localparam logic [3:0] RFN = 4'b0111;

    typedef struct packed {
        logic        rdy;
        logic        z;
        logic        lt;
        logic [18:0] e;
    } cyc_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       alu_zero = 1'b0;
    logic       alu_lt = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, addr_sel, ir_write, pc_write;
    logic [1:0] pc_src, alu_src_a, alu_src_b, wb_src;
    logic [3:0] aluop;
    logic       reg_write, trap;
    logic [18:0] obs;

    int total = 0;
    int bad = 0;
    cyc_t q[$];

    multicycle_control dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct3    (funct3),
        .alu_zero  (alu_zero),
        .alu_lt    (alu_lt),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .aluop     (aluop),
        .reg_write (reg_write),
        .wb_src    (wb_src),
        .trap      (trap)
    );

    always #5 clk = ~clk;

    assign obs = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
                  alu_src_a, alu_src_b, aluop, reg_write, wb_src, trap};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] mk(
        input logic req, we, asel, irw, pcw,
        input logic [1:0] pcs, a, b,
        input logic [3:0] aop,
        input logic rw,
        input logic [1:0] wbs,
        input logic tr);
        return {req, we, asel, irw, pcw, pcs, a, b, aop, rw, wbs, tr};
    endfunction

    function automatic logic is_legal(input logic [6:0] o);
        return o inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                         7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                         7'b0100011};
    endfunction

    function automatic cyc_t c(input logic rdy, input logic [18:0] e);
        cyc_t r;
        r.rdy = rdy;
        r.z   = 1'($urandom);
        r.lt  = 1'($urandom);
        r.e   = e;
        return r;
    endfunction

    task automatic play(input string name);
        int i = 0;
        while (q.size() > 0) begin
            cyc_t x = q.pop_front();
            mem_ready = x.rdy;
            alu_zero  = x.z;
            alu_lt    = x.lt;
            @(negedge clk);
            check($sformatf("%s.c%0d", name, i), 32'(obs), 32'(x.e));
            @(posedge clk);
            #1;
            i++;
        end
    endtask

    task automatic do_reset(input string name);
        reset     = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check({name, ".rst"}, 32'(obs), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // kinds: 0 R,1 I,2 LUI,3 AUIPC,4 JAL,5 JALR,6 BR,7 LW,8 SW,
    // 9 bad op,10 bad branch funct3,11 fetch timeout,12 reset mid-load
    task automatic run_instr(input int kind, input logic [6:0] bad_op);
        logic [18:0] fw0, fw1, dec, wba, tw, rd;
        logic [2:0]  f3;
        logic        tk;
        cyc_t        x;
        int          fd, md;
        string       nm;
        fw0 = mk(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, ADD, 0, 2'b00, 0);
        fw1 = mk(1, 0, 0, 1, 1, 2'b00, 2'b00, 2'b10, ADD, 0, 2'b00, 0);
        dec = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ADD, 0, 2'b00, 0);
        wba = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 1, 2'b00, 0);
        tw  = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 0, 2'b00, 1);
        nm  = $sformatf("k%0d", kind);
        f3  = 3'($urandom);
        case (kind)
            0: op = 7'b0110011;
            1: op = 7'b0010011;
            2: op = 7'b0110111;
            3: op = 7'b0010111;
            4: op = 7'b1101111;
            5: op = 7'b1100111;
            6: begin
                op = 7'b1100011;
                f3 = {1'($urandom), 1'b0, 1'($urandom)};
            end
            7, 12: op = 7'b0000011;
            8: op = 7'b0100011;
            9: op = bad_op;
            10: begin
                op = 7'b1100011;
                f3 = {1'($urandom), 1'b1, 1'($urandom)};
            end
            default: op = 7'b0110011;
        endcase
        funct3 = f3;
        if (kind == 11) begin
            fd = 16;
        end else begin
            fd = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 2);
        end
        for (int i = 0; i < fd; i++) q.push_back(c(1'b0, fw0));
        if (kind == 11) begin
            for (int i = 0; i < 3; i++) q.push_back(c(1'($urandom), tw));
            play(nm);
            do_reset(nm);
            return;
        end
        q.push_back(c(1'b1, fw1));
        q.push_back(c(1'($urandom), dec));
        case (kind)
            0: begin
                q.push_back(c(1'($urandom),
                    mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, RFN, 0, 2'b00, 0)));
                q.push_back(c(1'($urandom), wba));
            end
            1: begin
                q.push_back(c(1'($urandom),
                    mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, IFN, 0, 2'b00, 0)));
                q.push_back(c(1'($urandom), wba));
            end
            2, 3: begin
                q.push_back(c(1'($urandom),
                    mk(0, 0, 0, 0, 0, 2'b00, (kind == 2) ? 2'b11 : 2'b10,
                       2'b01, ADD, 0, 2'b00, 0)));
                q.push_back(c(1'($urandom), wba));
            end
            4: q.push_back(c(1'($urandom),
                   mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, ADD, 1, 2'b10, 0)));
            5: q.push_back(c(1'($urandom),
                   mk(0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b01, ADD, 1, 2'b10, 0)));
            6, 10: begin
                x = c(1'($urandom), 19'd0);
                case (f3)
                    3'b000:  tk = x.z;
                    3'b001:  tk = !x.z;
                    3'b100:  tk = x.lt;
                    3'b101:  tk = !x.lt;
                    default: tk = 1'b0;
                endcase
                x.e = mk(0, 0, 0, 0, tk, 2'b01, 2'b01, 2'b00, SUB, 0, 2'b00, 0);
                q.push_back(x);
                if (kind == 10) begin
                    for (int i = 0; i < 3; i++) q.push_back(c(1'($urandom), tw));
                end
            end
            7, 8, 12: begin
                q.push_back(c(1'($urandom),
                    mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, ADD, 0, 2'b00, 0)));
                rd = mk(1, kind == 8, 1, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 0, 2'b00, 0);
                md = (kind == 12) ? 2 : $urandom_range(0, 3);
                for (int i = 0; i < md; i++) q.push_back(c(1'b0, rd));
                if (kind != 12) begin
                    q.push_back(c(1'b1, rd));
                    if (kind == 7)
                        q.push_back(c(1'($urandom),
                            mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 1, 2'b01, 0)));
                end
            end
            9: for (int i = 0; i < 3; i++) q.push_back(c(1'($urandom), tw));
            default: ;
        endcase
        play(nm);
        if (kind inside {9, 10, 12}) do_reset(nm);
    endtask

    initial begin
        logic [6:0] bo;
        do_reset("init");
        run_instr(0, 7'd0);
        run_instr(9, 7'b1111111);
        run_instr(11, 7'd0);
        run_instr(12, 7'd0);
        run_instr(7, 7'd0);
        run_instr(8, 7'd0);
        for (int n = 0; n < 300; n++) begin
            bo = 7'($urandom);
            while (is_legal(bo)) bo = 7'($urandom);
            run_instr(($urandom_range(0, 19) == 0) ? $urandom_range(9, 12)
                                                   : $urandom_range(0, 8), bo);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
